ppu_pixel_sink: RTL and testbench

Responder for the PPU output handshake (stb/ack). It accepts 8-bit RRGGBBxx pixel words into a small FIFO and drains one word per active pixel of a 640x480p60 raster (800x525 total) it times itself. It drives registered VGA colour, sync and data-enable outputs, and reports underflow and start-of-frame. It sits between the PPU and the board VGA pins and replaces direct wiring of PPU data to the driver.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/ppu_pixel_sink_fifo.sv | 66 ++++++
 rtl/ppu_pixel_sink.sv | 141 ++++++++++++++
 tb/tb_ppu_pixel_sink.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared 640x480p60 raster timing (800x525 total) and the layout of the
//   8-bit RRGGBBxx pixel word. Imported by the PPU and by the pixel sink.
//   No ports: constants, an RGB struct and a word-to-colour helper.
package vga_pkg;

  // Horizontal timing in pixels, vertical timing in lines.
  localparam int HA_END = 639;  // last active pixel
  localparam int HS_STA = 655;  // first hsync pixel
  localparam int HS_END = 751;  // first pixel after hsync
  localparam int LINE   = 799;  // last pixel on a line
  localparam int VA_END = 479;  // last active line
  localparam int VS_STA = 489;  // first vsync line
  localparam int VS_END = 491;  // first line after vsync
  localparam int SCREEN = 524;  // last line of a frame

  // Width of the raster counters; covers both LINE and SCREEN.
  localparam int CNT_W = 10;

  // Pixel word layout: [7:6]=R, [5:4]=G, [3:2]=B, [1:0] unused.
  localparam int PIX_W    = 8;
  localparam int PIX_R_HI = 7;
  localparam int PIX_R_LO = 6;
  localparam int PIX_G_HI = 5;
  localparam int PIX_G_LO = 4;
  localparam int PIX_B_HI = 3;
  localparam int PIX_B_LO = 2;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  function automatic rgb_t pixel_to_rgb(input logic [PIX_W-1:0] w);
    rgb_t c;
    c.r = w[PIX_R_HI:PIX_R_LO];
    c.g = w[PIX_G_HI:PIX_G_LO];
    c.b = w[PIX_B_HI:PIX_B_LO];
    return c;
  endfunction

endpackage

// File: rtl/ppu_pixel_sink_fifo.sv
// sync_fifo
//   Single-clock first-word-fall-through FIFO. The head word is visible on
//   o_data whenever o_empty is low; a pop simply advances past it.
//   Ports:
//     clk, rst        clock, synchronous active-high reset (pointers/count)
//     i_push, i_data  write request and word (ignored when full)
//     i_pop           read request (ignored when empty)
//     o_data          head word
//     o_full/o_empty  occupancy flags
//     o_count         occupancy, 0..DEPTH
module sync_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4,
  parameter int WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_pop,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [ADDR_BITS:0]   o_count
);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_count;
  logic                 w_wr;
  logic                 w_rd;

  assign o_full  = (r_count == (ADDR_BITS+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_wr = i_push && !o_full;
  assign w_rd = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + ADDR_BITS'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + ADDR_BITS'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (ADDR_BITS+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_BITS+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries data only and is never reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/ppu_pixel_sink.sv
// ppu_pixel_sink
//   Accepts PPU pixel words over a stb/ack handshake into a small FIFO and
//   drains one word per active pixel of a self-timed VGA raster.
//   Ports:
//     clk, rst             pixel clock, synchronous active-high reset
//     data_i, stb_i        pixel word and strobe from the PPU
//     ack_o                one-cycle accept pulse, the cycle after a push
//     vga_r/g/b            registered 2-bit colour
//     hsync, vsync         registered active-low syncs
//     de                   registered data enable
//     sof_o                pulse with the first active pixel of a frame
//     underflow_o          sticky: FIFO empty at an active pixel
//     fill_o               FIFO occupancy
module ppu_pixel_sink
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_BITS  = 4,
  parameter int HA_END     = vga_pkg::HA_END,
  parameter int HS_STA     = vga_pkg::HS_STA,
  parameter int HS_END     = vga_pkg::HS_END,
  parameter int LINE       = vga_pkg::LINE,
  parameter int VA_END     = vga_pkg::VA_END,
  parameter int VS_STA     = vga_pkg::VS_STA,
  parameter int VS_END     = vga_pkg::VS_END,
  parameter int SCREEN     = vga_pkg::SCREEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PIX_W-1:0]     data_i,
  input  logic                 stb_i,
  output logic                 ack_o,
  output logic [1:0]           vga_r,
  output logic [1:0]           vga_g,
  output logic [1:0]           vga_b,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic                 sof_o,
  output logic                 underflow_o,
  output logic [ADDR_BITS:0]   fill_o
);

  localparam logic [CNT_W-1:0] C_HA_END = CNT_W'(HA_END);
  localparam logic [CNT_W-1:0] C_HS_STA = CNT_W'(HS_STA);
  localparam logic [CNT_W-1:0] C_HS_END = CNT_W'(HS_END);
  localparam logic [CNT_W-1:0] C_LINE   = CNT_W'(LINE);
  localparam logic [CNT_W-1:0] C_VA_END = CNT_W'(VA_END);
  localparam logic [CNT_W-1:0] C_VS_STA = CNT_W'(VS_STA);
  localparam logic [CNT_W-1:0] C_VS_END = CNT_W'(VS_END);
  localparam logic [CNT_W-1:0] C_SCREEN = CNT_W'(SCREEN);

  logic [CNT_W-1:0]   r_sx;
  logic [CNT_W-1:0]   r_sy;
  logic               r_ack;
  logic               w_active;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [PIX_W-1:0]   w_head;
  logic [ADDR_BITS:0] w_count;

  logic               r_de_p1;
  logic               r_hs_p1;
  logic               r_vs_p1;
  logic               r_sof_p1;
  logic               r_uf;
  rgb_t               r_rgb_p1;

  assign w_active = (r_sx <= C_HA_END) && (r_sy <= C_VA_END);

  // The PPU keeps stb high through the ack cycle, so that cycle must not
  // count as a new request. Acceptance looks only at full, never at the pop.
  assign w_push = stb_i && !r_ack && !w_full;
  assign w_pop  = w_active && !w_empty;

  sync_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .ADDR_BITS (ADDR_BITS),
    .WIDTH     (PIX_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (data_i),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sx <= '0;
      r_sy <= '0;
    end else if (r_sx == C_LINE) begin
      r_sx <= '0;
      r_sy <= (r_sy == C_SCREEN) ? '0 : r_sy + CNT_W'(1);
    end else begin
      r_sx <= r_sx + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_ack <= 1'b0;
    else     r_ack <= w_push;
  end

  // Stage p0 -> p1: counters and FIFO head registered onto the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_de_p1  <= 1'b0;
      r_hs_p1  <= 1'b1;
      r_vs_p1  <= 1'b1;
      r_sof_p1 <= 1'b0;
      r_rgb_p1 <= '0;
      r_uf     <= 1'b0;
    end else begin
      r_de_p1  <= w_active;
      r_hs_p1  <= ~((r_sx >= C_HS_STA) && (r_sx < C_HS_END));
      r_vs_p1  <= ~((r_sy >= C_VS_STA) && (r_sy < C_VS_END));
      r_sof_p1 <= (r_sx == '0) && (r_sy == '0);
      r_rgb_p1 <= w_pop ? pixel_to_rgb(w_head) : '0;
      if (w_active && w_empty) r_uf <= 1'b1;
    end
  end

  assign ack_o       = r_ack;
  assign vga_r       = r_rgb_p1.r;
  assign vga_g       = r_rgb_p1.g;
  assign vga_b       = r_rgb_p1.b;
  assign hsync       = r_hs_p1;
  assign vsync       = r_vs_p1;
  assign de          = r_de_p1;
  assign sof_o       = r_sof_p1;
  assign underflow_o = r_uf;
  assign fill_o      = w_count;

endmodule

// File: tb/tb_ppu_pixel_sink.sv
// Bench for ppu_pixel_sink. Horizontal timing is the real 640-wide line;
// the frame is shortened to 17 lines so whole frames fit in a short run.
module tb_ppu_pixel_sink;

  localparam int HA_END = 639;
  localparam int HS_STA = 655;
  localparam int HS_END = 751;
  localparam int LINE   = 799;
  localparam int VA_END = 9;
  localparam int VS_STA = 12;
  localparam int VS_END = 14;
  localparam int SCREEN = 16;
  localparam int DEPTH  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_i = '0;
  logic       stb_i = 1'b0;
  logic       ack_o;
  logic [1:0] vga_r, vga_g, vga_b;
  logic       hsync, vsync, de, sof_o, underflow_o;
  logic [4:0] fill_o;

  ppu_pixel_sink #(
    .FIFO_DEPTH (DEPTH), .ADDR_BITS (4),
    .HA_END (HA_END), .HS_STA (HS_STA), .HS_END (HS_END), .LINE (LINE),
    .VA_END (VA_END), .VS_STA (VS_STA), .VS_END (VS_END), .SCREEN (SCREEN)
  ) dut (
    .clk (clk), .rst (rst), .data_i (data_i), .stb_i (stb_i), .ack_o (ack_o),
    .vga_r (vga_r), .vga_g (vga_g), .vga_b (vga_b),
    .hsync (hsync), .vsync (vsync), .de (de), .sof_o (sof_o),
    .underflow_o (underflow_o), .fill_o (fill_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: raster position of the current cycle, the
  // scoreboard of accepted words, and the outputs expected after each edge.
  int         msx = 0;
  int         msy = 0;
  logic [7:0] q[$];
  logic       m_ack = 1'b0;
  logic       e_de = 1'b0, e_hs = 1'b1, e_vs = 1'b1, e_sof = 1'b0, e_uf = 1'b0;
  logic [5:0] e_rgb = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       act, push;
    logic [7:0] w;
    forever begin
      @(posedge clk);
      if (rst) begin
        msx = 0; msy = 0; q.delete(); m_ack = 1'b0;
        e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_sof = 1'b0; e_uf = 1'b0; e_rgb = '0;
      end else begin
        act   = (msx <= HA_END) && (msy <= VA_END);
        push  = stb_i && !m_ack && (q.size() < DEPTH);
        e_de  = act;
        e_hs  = !((msx >= HS_STA) && (msx < HS_END));
        e_vs  = !((msy >= VS_STA) && (msy < VS_END));
        e_sof = (msx == 0) && (msy == 0);
        if (act && q.size() == 0) begin
          e_uf = 1'b1; e_rgb = '0;
        end else if (act) begin
          w = q.pop_front(); e_rgb = w[7:2];
        end else begin
          e_rgb = '0;
        end
        if (push) q.push_back(data_i);
        m_ack = push;
        if (msx == LINE) begin
          msx = 0; msy = (msy == SCREEN) ? 0 : msy + 1;
        end else begin
          msx = msx + 1;
        end
      end
    end
  end

  // Every cycle, compare all outputs with the model.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("sb_ack", ack_o, m_ack);
      check("sb_de", de, e_de);
      check("sb_hsync", hsync, e_hs);
      check("sb_vsync", vsync, e_vs);
      check("sb_sof", sof_o, e_sof);
      check("sb_underflow", underflow_o, e_uf);
      check("sb_rgb", {vga_r, vga_g, vga_b}, e_rgb);
      check("sb_fill", fill_o, q.size());
    end
  end

  task automatic wait_pos(input int x, input int y, input int budget);
    bit hit = 0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(posedge clk); #1;
      if (msx == x && msy == y) hit = 1;
    end
    check("wait_pos", hit, 1);
  endtask

  task automatic push_word(input logic [7:0] d, input int budget, output bit got);
    got = 0;
    stb_i = 1'b1; data_i = d;
    for (int n = 0; n < budget && !got; n++) begin
      @(posedge clk); #1;
      if (ack_o === 1'b1) got = 1;
    end
    stb_i = 1'b0;
  endtask

  initial begin
    bit got;
    int cnt_a, cnt_b, cnt_c, first_x, first_y;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", ack_o, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_de", de, 0);
    check("rst_fill", fill_o, 0);
    check("rst_underflow", underflow_o, 0);
    @(posedge clk); #1 rst = 1'b0;

    // First cycle out of reset is (0,0) with an empty FIFO: sof and underflow.
    @(posedge clk);
    @(negedge clk);
    check("sof_first", sof_o, 1);
    check("uf_set", underflow_o, 1);
    check("uf_rgb", {vga_r, vga_g, vga_b}, 0);
    check("uf_de", de, 1);
    @(negedge clk);
    check("sof_once", sof_o, 0);

    // Single handshake with stb held through the ack cycle.
    wait_pos(650, 0, 2000);
    stb_i = 1'b1; data_i = 8'hC0;
    @(posedge clk); #1;
    check("hs_ack", ack_o, 1);
    check("hs_fill1", fill_o, 1);
    @(posedge clk); #1;
    check("hs_ack_once", ack_o, 0);
    check("hs_no_second", fill_o, 1);
    stb_i = 1'b0;

    // Fill to full in blanking, then a held strobe is refused until a pop.
    for (int i = 0; i < 15; i++) begin
      push_word(8'(i * 17 + 3), 4, got);
      check("fill_ack", got, 1);
    end
    check("fill_full", fill_o, 16);
    stb_i = 1'b1; data_i = 8'h5A;
    cnt_a = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ack_o === 1'b1) cnt_a++;
    end
    check("full_noack", cnt_a, 0);
    push_word(8'h5A, 400, got);
    check("full_ack_after_pop", got, 1);
    check("full_ack_sx", msx, 2);
    check("full_ack_sy", msy, 1);

    // Pixel ordering: three words preloaded just before line 3.
    wait_pos(795, 2, 3000);
    push_word(8'hC0, 4, got); check("pre_ack0", got, 1);
    push_word(8'h30, 4, got); check("pre_ack1", got, 1);
    push_word(8'h0C, 4, got); check("pre_ack2", got, 1);
    wait_pos(1, 3, 10);
    @(negedge clk);
    check("pix0_rgb", {vga_r, vga_g, vga_b}, 6'b110000);
    check("pix0_de", de, 1);
    @(negedge clk);
    check("pix1_rgb", {vga_r, vga_g, vga_b}, 6'b001100);
    check("pix1_de", de, 1);
    @(negedge clk);
    check("pix2_rgb", {vga_r, vga_g, vga_b}, 6'b000011);
    check("pix2_de", de, 1);

    // Underflow stays set a full frame later.
    wait_pos(1, 3, 20000);
    check("uf_sticky", underflow_o, 1);

    // One active line: hsync and de counts.
    wait_pos(0, 4, 20000);
    cnt_a = 0; cnt_b = 0; first_x = -1;
    repeat (LINE + 1) begin
      @(negedge clk);
      if (hsync === 1'b0) begin
        if (first_x < 0) first_x = msx;
        cnt_a++;
      end
      if (de === 1'b1) cnt_b++;
    end
    check("hsync_len", cnt_a, 96);
    check("hsync_start", first_x, HS_STA + 1);
    check("de_line", cnt_b, HA_END + 1);

    // One whole frame: vsync, de and sof counts.
    wait_pos(0, 0, 20000);
    cnt_a = 0; cnt_b = 0; cnt_c = 0; first_x = -1; first_y = -1;
    repeat ((LINE + 1) * (SCREEN + 1)) begin
      @(negedge clk);
      if (vsync === 1'b0) begin
        if (first_x < 0) begin first_x = msx; first_y = msy; end
        cnt_a++;
      end
      if (de === 1'b1) cnt_b++;
      if (sof_o === 1'b1) cnt_c++;
    end
    check("vsync_len", cnt_a, 2 * (LINE + 1));
    check("vsync_start_x", first_x, 1);
    check("vsync_start_y", first_y, VS_STA);
    check("de_frame", cnt_b, (HA_END + 1) * (VA_END + 1));
    check("sof_frame", cnt_c, 1);

    // Reset in the ack cycle drops the pending ack and the stored word.
    wait_pos(700, 0, 20000);
    stb_i = 1'b1; data_i = 8'hFC;
    @(posedge clk); #1;
    check("mid_ack", ack_o, 1);
    rst = 1'b1; stb_i = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_ack", ack_o, 0);
    check("mid_rst_fill", fill_o, 0);
    check("mid_rst_uf", underflow_o, 0);
    check("mid_rst_hsync", hsync, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_sof", sof_o, 1);
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
